// File: rtl/dmx_frame_sequencer_pkg.sv
// Shared types and constants for the DMX512 frame sequencer and its prefetch buffer.
// Timing defaults assume a 27 MHz system clock.
package dmx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BREAK  = 3'd1,
    ST_MAB    = 3'd2,
    ST_SEND   = 3'd3,
    ST_TXWAIT = 3'd4,
    ST_MBB    = 3'd5
  } dmx_state_e;

  localparam logic [7:0] DMX_START_CODE = 8'h00;
  // Byte substituted for a slot whose lookup came back with the wrong address
  localparam logic [7:0] DMX_FAULT_BYTE = 8'h00;

  localparam int DMX_MAX_SLOTS = 512;

  localparam int DMX_DEF_BREAK_CYCLES   = 2700;
  localparam int DMX_DEF_MAB_CYCLES     = 324;
  localparam int DMX_DEF_MBB_CYCLES     = 0;
  localparam int DMX_DEF_LOOKUP_LATENCY = 2;

  // Cycles at the start of TXWAIT in which tx_busy has not yet caught up with tx_start
  localparam logic [15:0] DMX_TXWAIT_BLIND = 16'd2;

endpackage

// File: rtl/dmx_frame_sequencer_prefetch_buf.sv
// One-deep lookup tracker: remembers the outstanding request address, times the
// processor latency, and holds the returned byte until the sequencer sends it.
module dmx_prefetch_buf
  import dmx_pkg::*;
#(
  parameter int LOOKUP_LATENCY = DMX_DEF_LOOKUP_LATENCY
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic [8:0] i_req_addr,
  input  logic       i_consume,
  input  logic [8:0] i_proc_addr,
  input  logic [7:0] i_proc_data,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_addr_err
);

  logic [LOOKUP_LATENCY-1:0] r_lat;
  logic [LOOKUP_LATENCY:0]   w_taps;
  logic                      w_capture;
  logic                      w_match;
  logic [8:0]                r_pend_addr;
  logic [7:0]                r_data;
  logic                      r_valid;
  logic                      r_addr_err;

  // Tap LOOKUP_LATENCY is high exactly in the cycle the processor result is valid
  assign w_taps    = {r_lat, i_req};
  assign w_capture = w_taps[LOOKUP_LATENCY];
  assign w_match   = (i_proc_addr == r_pend_addr);

  // Latency pipe, pending address, buffer and sticky address-error flag
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lat       <= '0;
      r_pend_addr <= 9'd0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_lat <= w_taps[LOOKUP_LATENCY-1:0];
      if (i_req) begin
        r_pend_addr <= i_req_addr;
      end
      if (w_capture) begin
        r_valid <= 1'b1;
        r_data  <= w_match ? i_proc_data : DMX_FAULT_BYTE;
        if (!w_match) begin
          r_addr_err <= 1'b1;
        end
      end else if (i_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_addr_err = r_addr_err;

endmodule

// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame sequencer: break / mark-after-break / start code / slot bytes,
// with one-slot-ahead lookups into dmx_processor so the serializer never waits.
module dmx_frame_sequencer
  import dmx_pkg::*;
#(
  parameter int NUM_SLOTS      = DMX_MAX_SLOTS,
  parameter int BREAK_CYCLES   = DMX_DEF_BREAK_CYCLES,
  parameter int MAB_CYCLES     = DMX_DEF_MAB_CYCLES,
  parameter int MBB_CYCLES     = DMX_DEF_MBB_CYCLES,
  parameter int LOOKUP_LATENCY = DMX_DEF_LOOKUP_LATENCY
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  output logic [8:0] o_request_addr,
  output logic       o_request_pulse,
  input  logic [8:0] i_proc_addr,
  input  logic [7:0] i_proc_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_busy,
  output logic       o_line_break,
  output logic       o_frame_done,
  output logic       o_busy,
  output logic       o_addr_err
);

  localparam logic [15:0] BREAK_LAST = 16'(BREAK_CYCLES - 1);
  localparam logic [15:0] MAB_LAST   = 16'(MAB_CYCLES - 1);
  localparam logic [15:0] MBB_LAST   = 16'(MBB_CYCLES - 1);
  localparam logic [9:0]  LAST_SLOT  = 10'(NUM_SLOTS);
  localparam bit          MBB_SKIP   = (MBB_CYCLES == 0);

  dmx_state_e  r_state;
  dmx_state_e  w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [9:0]  r_slot;
  logic [9:0]  w_slot_nxt;
  logic        w_launch;
  logic [9:0]  w_launch_slot;
  logic        w_consume;
  logic        r_req_pulse;
  logic        w_req_nxt;
  logic [8:0]  r_req_addr;
  logic [8:0]  w_req_addr_nxt;
  logic        r_tx_start;
  logic        w_tx_start_nxt;
  logic [7:0]  r_tx_data;
  logic [7:0]  w_tx_data_nxt;
  logic        r_frame_done;
  logic        w_frame_done_nxt;
  logic        r_line_break;
  logic        r_busy;
  logic        w_buf_valid;
  logic [7:0]  w_buf_data;

  dmx_prefetch_buf #(
    .LOOKUP_LATENCY(LOOKUP_LATENCY)
  ) u_prefetch (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (r_req_pulse),
    .i_req_addr (r_req_addr),
    .i_consume  (w_consume),
    .i_proc_addr(i_proc_addr),
    .i_proc_data(i_proc_data),
    .o_valid    (w_buf_valid),
    .o_data     (w_buf_data),
    .o_addr_err (o_addr_err)
  );

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_slot_nxt       = r_slot;
    w_launch         = 1'b0;
    w_launch_slot    = r_slot;
    w_consume        = 1'b0;
    w_req_nxt        = 1'b0;
    w_req_addr_nxt   = r_req_addr;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    w_frame_done_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_BREAK;
          w_cnt_nxt   = 16'd0;
          w_slot_nxt  = 10'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (r_cnt == BREAK_LAST) begin
          w_state_nxt    = ST_MAB;
          w_cnt_nxt      = 16'd0;
          w_req_nxt      = 1'b1;
          w_req_addr_nxt = 9'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_MAB: begin
        if (r_cnt == MAB_LAST) begin
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_SEND: begin
        if (!i_tx_busy && ((r_slot == 10'd0) || w_buf_valid)) begin
          w_launch      = 1'b1;
          w_launch_slot = r_slot;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_TXWAIT: begin
        // A ready next byte launches straight from TXWAIT, saving the SEND cycle
        if (r_cnt < DMX_TXWAIT_BLIND) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end else if (i_tx_busy) begin
          w_state_nxt = ST_TXWAIT;
        end else if (r_slot != LAST_SLOT) begin
          if (w_buf_valid) begin
            w_launch      = 1'b1;
            w_launch_slot = r_slot + 10'd1;
          end else begin
            w_state_nxt = ST_SEND;
            w_slot_nxt  = r_slot + 10'd1;
          end
        end else begin
          w_frame_done_nxt = 1'b1;
          w_cnt_nxt        = 16'd0;
          if (!MBB_SKIP) begin
            w_state_nxt = ST_MBB;
          end else if (i_enable) begin
            w_state_nxt = ST_BREAK;
            w_slot_nxt  = 10'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_MBB: begin
        if (r_cnt == MBB_LAST) begin
          w_cnt_nxt   = 16'd0;
          w_slot_nxt  = 10'd0;
          w_state_nxt = i_enable ? ST_BREAK : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
        w_slot_nxt  = 10'd0;
      end
    endcase

    // Slot 1 was already requested during MAB, so the start code launches no lookup
    if (w_launch) begin
      w_state_nxt    = ST_TXWAIT;
      w_cnt_nxt      = 16'd0;
      w_slot_nxt     = w_launch_slot;
      w_tx_start_nxt = 1'b1;
      if (w_launch_slot == 10'd0) begin
        w_tx_data_nxt = DMX_START_CODE;
      end else begin
        w_tx_data_nxt = w_buf_data;
        w_consume     = 1'b1;
      end
      if ((w_launch_slot != 10'd0) && (w_launch_slot != LAST_SLOT)) begin
        w_req_nxt      = 1'b1;
        w_req_addr_nxt = w_launch_slot[8:0];
      end else begin
        w_req_nxt = 1'b0;
      end
    end else begin
      w_consume = 1'b0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 16'd0;
      r_slot       <= 10'd0;
      r_req_pulse  <= 1'b0;
      r_req_addr   <= 9'd0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_frame_done <= 1'b0;
      r_line_break <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_slot       <= w_slot_nxt;
      r_req_pulse  <= w_req_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_line_break <= (w_state_nxt == ST_BREAK);
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_request_addr  = r_req_addr;
  assign o_request_pulse = r_req_pulse;
  assign o_tx_data       = r_tx_data;
  assign o_tx_start      = r_tx_start;
  assign o_line_break    = r_line_break;
  assign o_frame_done    = r_frame_done;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Directed bench for dmx_frame_sequencer with stub processor (echo, data=addr+0x10)
// and stub serializer (busy for a programmable number of cycles after tx_start).
module tb_dmx_frame_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [8:0] request_addr;
  logic       request_pulse;
  logic [8:0] proc_addr;
  logic [7:0] proc_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       line_break;
  logic       frame_done;
  logic       busy;
  logic       addr_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_len = 5;
  logic fault = 1'b0;

  int tx_q[$];
  int tx_cyc_q[$];
  int req_q[$];
  int req_cyc_q[$];
  int fd_cyc_q[$];
  int lb_rise_q[$];
  int lb_len_q[$];
  int lb_run = 0;
  logic lb_prev = 1'b0;

  int exp_bytes[4] = '{0, 16, 17, 18};
  int exp_fault_bytes[4] = '{0, 16, 0, 18};
  int exp_cyc[4] = '{15, 22, 29, 36};

  logic [8:0] s1_addr, s2_addr;
  logic       s1_fault, s2_fault;
  int         bcnt;

  dmx_frame_sequencer #(
    .NUM_SLOTS(3), .BREAK_CYCLES(10), .MAB_CYCLES(3), .MBB_CYCLES(2), .LOOKUP_LATENCY(2)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .o_request_addr(request_addr), .o_request_pulse(request_pulse),
    .i_proc_addr(proc_addr), .i_proc_data(proc_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy),
    .o_line_break(line_break), .o_frame_done(frame_done),
    .o_busy(busy), .o_addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub processor: result valid two cycles after the request cycle
  always @(posedge clk) begin
    s1_addr  <= request_addr;
    s2_addr  <= s1_addr;
    s1_fault <= fault && request_pulse && (request_addr == 9'd1);
    s2_fault <= s1_fault;
  end
  assign proc_addr = s2_fault ? 9'd5 : s2_addr;
  assign proc_data = s2_addr[7:0] + 8'h10;

  // Stub serializer
  always @(posedge clk) begin
    if (!reset) bcnt <= 0;
    else if (tx_start) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_start) begin
      tx_q.push_back(int'(tx_data));
      tx_cyc_q.push_back(cyc);
    end
    if (request_pulse) begin
      req_q.push_back(int'(request_addr));
      req_cyc_q.push_back(cyc);
    end
    if (frame_done) fd_cyc_q.push_back(cyc);
    if (line_break && !lb_prev) begin
      lb_rise_q.push_back(cyc);
      lb_run <= 1;
    end else if (line_break) begin
      lb_run <= lb_run + 1;
    end
    if (!line_break && lb_prev) lb_len_q.push_back(lb_run);
    lb_prev <= line_break;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(input int target, input int limit, input string tag);
    int n = 0;
    while (fd_cyc_q.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, fd_cyc_q.size(), target);
  endtask

  task automatic wait_tx(input int target, input int limit, input string tag);
    int n = 0;
    while (tx_q.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, (tx_q.size() >= target) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int b_tx, b_req, b_fd, b_lb, b_len;
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_outputs", {request_addr, request_pulse, tx_data, tx_start,
                          line_break, frame_done, busy, addr_err}, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_line_break", line_break, 1'b0);

    // Basic frame followed by a continuous second frame
    b_tx = tx_q.size(); b_req = req_q.size(); b_fd = fd_cyc_q.size();
    b_lb = lb_rise_q.size(); b_len = lb_len_q.size();
    reset = 1'b1; enable = 1'b1; t0 = cyc;
    wait_fd(b_fd + 2, 300, "t1_two_frames");
    repeat (3) @(negedge clk);
    check("t1_break_latency", lb_rise_q[b_lb] - t0, 1);
    check("t1_break_len", lb_len_q[b_len], 10);
    check("t1_req1_cycle", req_cyc_q[b_req] - t0, 11);
    for (int i = 0; i < 3; i++) check($sformatf("t1_req_addr%0d", i), req_q[b_req + i], i);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_byte%0d", i), tx_q[b_tx + i], exp_bytes[i]);
      check($sformatf("t1_tx_cycle%0d", i), tx_cyc_q[b_tx + i] - t0, exp_cyc[i]);
    end
    check("t1_frame_done_cycle", fd_cyc_q[b_fd] - t0, 43);
    check("t1_break2_gap", lb_rise_q[b_lb + 1] - fd_cyc_q[b_fd], 2);
    check("t1_break2_len", lb_len_q[b_len + 1], 10);
    for (int i = 0; i < 4; i++) check($sformatf("t1_f2_byte%0d", i), tx_q[b_tx + 4 + i], exp_bytes[i]);
    check("t1_req_count", req_q.size() - b_req, 6);
    check("t1_addr_err", addr_err, 1'b0);

    // Address fault on the slot 2 lookup, sticky across frames
    do_reset();
    b_tx = tx_q.size(); b_fd = fd_cyc_q.size();
    fault = 1'b1; reset = 1'b1; enable = 1'b1;
    wait_fd(b_fd + 1, 200, "t2_frame1");
    fault = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("t2_byte%0d", i), tx_q[b_tx + i], exp_fault_bytes[i]);
    check("t2_addr_err_f1", addr_err, 1'b1);
    wait_fd(b_fd + 2, 200, "t2_frame2");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("t2_f2_byte%0d", i), tx_q[b_tx + 4 + i], exp_bytes[i]);
    check("t2_addr_err_f2", addr_err, 1'b1);

    // Slow serializer, single frame (enable dropped during the break)
    do_reset();
    check("t3_addr_err_cleared", addr_err, 1'b0);
    b_tx = tx_q.size(); b_req = req_q.size(); b_fd = fd_cyc_q.size();
    busy_len = 40; reset = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_fd(b_fd + 1, 600, "t3_frame");
    repeat (10) @(negedge clk);
    check("t3_req_count", req_q.size() - b_req, 3);
    check("t3_tx_count", tx_q.size() - b_tx, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_byte%0d", i), tx_q[b_tx + i], exp_bytes[i]);
    check("t3_slot_gap", tx_cyc_q[b_tx + 1] - tx_cyc_q[b_tx], 42);
    check("t3_fd_count", fd_cyc_q.size() - b_fd, 1);

    // Enable drop during slot 1
    do_reset();
    b_tx = tx_q.size(); b_fd = fd_cyc_q.size(); b_lb = lb_rise_q.size();
    busy_len = 5; reset = 1'b1; enable = 1'b1;
    wait_tx(b_tx + 2, 100, "t4_slot1_seen");
    enable = 1'b0;
    wait_fd(b_fd + 1, 100, "t4_frame");
    repeat (20) @(negedge clk);
    check("t4_tx_count", tx_q.size() - b_tx, 4);
    check("t4_byte3", tx_q[b_tx + 3], 18);
    check("t4_fd_count", fd_cyc_q.size() - b_fd, 1);
    check("t4_busy_idle", busy, 1'b0);
    check("t4_break_count", lb_rise_q.size() - b_lb, 1);

    // Reset during slot 2
    do_reset();
    b_tx = tx_q.size();
    reset = 1'b1; enable = 1'b1;
    wait_tx(b_tx + 3, 100, "t5_slot2_seen");
    b_fd = fd_cyc_q.size();
    reset = 1'b0;
    @(negedge clk);
    check("t5_outputs_zero", {request_addr, request_pulse, tx_data, tx_start,
                              line_break, frame_done, busy, addr_err}, 32'd0);
    repeat (3) @(negedge clk);
    check("t5_no_frame_done", fd_cyc_q.size(), b_fd);
    check("t5_tx_count", tx_q.size() - b_tx, 3);
    b_lb = lb_rise_q.size();
    reset = 1'b1; t0 = cyc;
    repeat (3) @(negedge clk);
    check("t5_new_break", lb_rise_q.size() - b_lb, 1);
    check("t5_break_latency", lb_rise_q[b_lb] - t0, 1);
    check("t5_line_break_high", line_break, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmx_frame_sequencer.md
# dmx_frame_sequencer

Frame-level controller for the DMX512 output path. It walks the slot index from 1 to NUM_SLOTS, issues lookups to dmx_processor through its request_addr/request_pulse port, and captures addr_out/data_out. Captured bytes go to the byte serializer under a busy handshake, framed by break, mark-after-break and start code. It sits between dmx_processor and the UART-style DMX transmitter, and prefetches one slot ahead so the serializer never idles between slots.

## Interface
- NUM_SLOTS, 512: data slots per frame (1..512).
- BREAK_CYCLES, 2700: break length in clk cycles (100 µs at 27 MHz).
- MAB_CYCLES, 324: mark-after-break length in cycles (12 µs).
- MBB_CYCLES, 0: idle mark between frames, in cycles.
- LOOKUP_LATENCY, 2: cycles from the request_pulse cycle to the cycle in which proc_addr/proc_data are valid (≥1).
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  level; frames run while high
- request_addr  out  9  slot index − 1 to dmx_processor
- request_pulse  out  1  one-cycle lookup strobe
- proc_addr  in  9  dmx_processor addr_out
- proc_data  in  8  dmx_processor data_out
- tx_data  out  8  byte to serializer
- tx_start  out  1  one-cycle send strobe
- tx_busy  in  1  serializer busy; rises the cycle after tx_start and holds until the stop bits finish
- line_break  out  1  high forces the DMX line to space (break)
- frame_done  out  1  one-cycle pulse after the last slot finishes
- busy  out  1  high whenever state ≠ IDLE
- addr_err  out  1  sticky; set on a lookup address mismatch

## Operation
- States: IDLE, BREAK, MAB, SEND, TXWAIT, MBB.
- IDLE: if enable=1, go to BREAK next cycle.
- BREAK: line_break=1 for exactly BREAK_CYCLES cycles, then MAB.
- MAB: line_break=0 for MAB_CYCLES cycles. request_pulse for slot 1 (request_addr=0) fires in the first MAB cycle.
- SEND: when tx_busy=0, pulse tx_start with tx_data equal to the current byte, then go to TXWAIT.
  - The first byte is the start code 0x00 and needs no lookup.
  - For data slots, SEND stalls until the prefetch buffer is valid.
- Prefetch buffer: one byte plus a valid flag.
  - Loaded LOOKUP_LATENCY cycles after each request_pulse.
  - Emptied in the tx_start cycle that consumes it. That same cycle issues request_pulse for the next slot, if one remains.
- Address check: at capture, if proc_addr ≠ the issued request_addr, the buffer loads 0x00 and addr_err sets. addr_err clears only on reset.
- TXWAIT: ignore tx_busy in the cycle after tx_start, then wait for tx_busy=0.
  - If more slots remain, return to SEND.
  - Otherwise pulse frame_done and go to MBB.
- MBB: count MBB_CYCLES (0 means skip). Then go to BREAK if enable=1, else IDLE.
- enable falling mid-frame: the current frame completes and the sequencer then idles.
- Slot counter is 10 bits wide, holds 0..NUM_SLOTS, and is reset at BREAK entry. It never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, buffer invalid, counters 0.
- Reset mid-frame: takes effect at the next clk edge, with no partial byte and no frame_done.
- Enable-to-line_break latency: 1 cycle from IDLE.
- Slot 1 tx_start occurs no later than 1 cycle after tx_busy falls on the start code, because its lookup completed during MAB.
- Minimum inter-slot gap: 2 cycles (tx_busy low, then tx_start), provided LOOKUP_LATENCY+1 ≤ serializer byte time.
- request_pulse and tx_start never coincide with a pending unconsumed buffer load. At most one lookup is outstanding.

## Structure
- dmx_pkg holds:
  - the state encoding;
  - the DMX start-code constant 0x00;
  - DMX_MAX_SLOTS=512;
  - default timing constants at 27 MHz.
- Lookup tracking (pending address, latency shift register, buffer, valid flag) lives in a sub-module, dmx_prefetch_buf. The top level holds the FSM and counters.

## Test plan
Bench parameters: NUM_SLOTS=3, BREAK_CYCLES=10, MAB_CYCLES=3, MBB_CYCLES=2, LOOKUP_LATENCY=2. The stub processor echoes the address and returns data = addr+0x10. The stub serializer holds busy for 5 cycles.
- Basic frame: enable=1 from reset.
  - line_break high for exactly 10 cycles, then 3 low MAB cycles.
  - tx bytes 0x00, 0x10, 0x11, 0x12 in order.
  - request_addr sequence 0, 1, 2.
  - One frame_done after byte 0x12.
- Continuous frames: with enable held high, the second break starts exactly 2 cycles after the first frame_done.
- Address fault: stub returns proc_addr=5 for request 1 → slot 2 byte is 0x00, addr_err=1 for the rest of the frame and across frames.
- Slow serializer: busy held 40 cycles per byte → exactly one request_pulse per slot and no dropped or duplicated bytes.
- Enable drop: enable=0 during slot 1 → the frame completes (4 bytes, frame_done), then IDLE with busy=0 and no new break.
- Reset mid-frame: reset=0 during slot 2 → the next cycle shows all outputs 0 and no frame_done. After release with enable=1, a fresh break starts.
